mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of the EXE/MEM pipeline register; consumes its WB enable, memory read/write enables, PC, ALU result, store value and destination fields.
- Performs loads and stores over a req/ack data-memory port with variable wait states, freezing upstream stages while an access is outstanding.
- Drives the registered MEM/WB outputs that feed the write-back stage.

Parameters:
- ADDR_BASE, 1024, byte address subtracted from ALU_result to form the memory offset.
- MEM_AW, 10, width of the word address driven to memory.
- TIMEOUT, 15, maximum BUSY cycles before an access is aborted (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- WB_en_in  in  1  write-back enable from EXE/MEM register.
- MEM_R_EN_in  in  1  load request.
- MEM_W_EN_in  in  1  store request.
- PC_in  in  32  instruction PC.
- ALU_result_in  in  32  effective byte address, or ALU value for non-memory instructions.
- ST_val_in  in  32  store data.
- Dest_in  in  5  destination register.
- freeze  out  1  combinational stall to the PC, IF, ID and EXE registers.
- mem_req  out  1  registered memory request.
- mem_we  out  1  registered; 1 = write.
- mem_addr  out  MEM_AW  registered word address.
- mem_wdata  out  32  registered store data.
- mem_rdata  in  32  read data; valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion strobe.
- WB_en  out  1  registered, to WB stage.
- MEM_R_EN  out  1  registered; selects mem data in WB.
- ALU_result  out  32  registered.
- MEM_read_value  out  32  registered load data.
- Dest  out  5  registered.
- PC  out  32  registered.
- mem_err  out  1  sticky timeout flag; cleared only by rst.
- misalign  out  1  one-cycle pulse (see optional feature).

Behaviour:
- Reset: all outputs, state and counters go to 0, and the FSM goes to IDLE. A reset during BUSY drops mem_req at that edge; a mem_ack arriving after reset is ignored.
- access = MEM_R_EN_in | MEM_W_EN_in. If both enables are set, the read wins and the write is suppressed.
- Word address = (ALU_result_in - ADDR_BASE) >> 2, truncated to MEM_AW bits; no range check.
- FSM states IDLE, BUSY, DONE.
- IDLE, access=0:
  - freeze=0.
  - The output register loads all *_in fields next edge (latency 1); MEM_read_value=0.
- IDLE, access=1:
  - freeze=1 combinationally.
  - Next edge: latch addr, wdata, we, WB_en_in, MEM_R_EN_in, Dest_in, PC_in and ALU_result_in; assert mem_req; clear the timeout counter; go BUSY.
  - Output register loads a bubble (WB_en=0, MEM_R_EN=0, other fields 0).
- BUSY:
  - freeze=1; mem_req/mem_we/mem_addr/mem_wdata held stable; the counter increments each cycle.
  - On an edge with mem_ack=1: drop mem_req, load the output register from the latched fields with MEM_read_value=mem_rdata (0 for a store), go DONE.
  - On an edge with counter==TIMEOUT-1 and no ack: drop mem_req, set mem_err, load the latched fields with WB_en forced 0, go DONE.
  - Otherwise the output register loads a bubble.
- DONE:
  - freeze=0, so upstream advances at this edge. The stale EXE/MEM contents are not reissued.
  - Output register loads a bubble; go IDLE.
- Memory op latency from issue: 2 + (ack wait cycles) to result.
- mem_ack outside BUSY is ignored.
- Stores produce WB_en as latched, normally 0.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, access with ALU_result_in[1:0]!=0 issues no mem_req and stays IDLE with freeze=0. The output register loads the fields with WB_en=0 and MEM_R_EN=0, and misalign pulses 1 for one cycle.
- Undefined: low address bits ignored; misalign tied 0.

Test Plan:
- ALU op WB_en=1, ALU_result=0x15, Dest=3 → next cycle WB_en=1, ALU_result=0x15, Dest=3, freeze never high.
- Load ALU_result=1032, mem_ack 3 cycles after mem_req, mem_rdata=0xCAFE0001 → mem_addr=2, mem_we=0, freeze high throughout; MEM_R_EN=1, MEM_read_value=0xCAFE0001 one cycle after ack; one DONE bubble; no re-issue.
- Store ALU_result=1024, ST_val=0x55AA → mem_we=1, mem_addr=0, mem_wdata=0x55AA; ack in the first BUSY cycle → WB_en out 0, total freeze 2 cycles.
- No ack for TIMEOUT=15 cycles → mem_req drops after 15 BUSY cycles, mem_err=1 and stays set, WB_en out 0, FSM back to IDLE two edges later.
- rst asserted mid-BUSY, then mem_ack pulsed → all outputs 0, mem_req 0, state IDLE, ack ignored.
- MEM_ALIGN_CHECK_EN: load at 1026 → no mem_req, misalign pulse, WB_en out 0; without the macro the same load gives mem_addr=0 and a normal access.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: EXE/MEM inputs -> registered MEM/WB outputs, with a req/ack data port.
// Optional build macro MEM_ALIGN_CHECK_EN rejects word-misaligned accesses without issuing them.
module mem_stage #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       ALU_result_in,
    input  logic [31:0]       ST_val_in,
    input  logic [4:0]        Dest_in,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic [31:0]       ALU_result,
    output logic [31:0]       MEM_read_value,
    output logic [4:0]        Dest,
    output logic [31:0]       PC,
    output logic              mem_err,
    output logic              misalign
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [7:0]        count;
    logic              lat_wb_en;
    logic              lat_r_en;
    logic [4:0]        lat_dest;
    logic [31:0]       lat_pc;
    logic [31:0]       lat_alu;

    logic              access;
    logic              misaligned;
    logic              issue;
    logic [31:0]       offset;
    logic [MEM_AW-1:0] word_addr;

    assign access    = MEM_R_EN_in | MEM_W_EN_in;
    assign offset    = ALU_result_in - 32'(ADDR_BASE);
    assign word_addr = MEM_AW'(offset >> 2);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access && (ALU_result_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign issue  = access && !misaligned;
    // DONE deliberately releases the stall so upstream advances past the finished access.
    assign freeze = (state == BUSY) || ((state == IDLE) && issue);

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            lat_wb_en      <= 1'b0;
            lat_r_en       <= 1'b0;
            lat_dest       <= '0;
            lat_pc         <= '0;
            lat_alu        <= '0;
            WB_en          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            ALU_result     <= '0;
            MEM_read_value <= '0;
            Dest           <= '0;
            PC             <= '0;
            mem_err        <= 1'b0;
            misalign       <= 1'b0;
        end else begin
            // Output register defaults to a bubble; each branch overrides what it forwards.
            WB_en          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            ALU_result     <= '0;
            MEM_read_value <= '0;
            Dest           <= '0;
            PC             <= '0;
            misalign       <= 1'b0;

            case (state)
                IDLE: begin
                    if (issue) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MEM_W_EN_in & ~MEM_R_EN_in;
                        mem_addr  <= word_addr;
                        mem_wdata <= ST_val_in;
                        lat_wb_en <= WB_en_in;
                        lat_r_en  <= MEM_R_EN_in;
                        lat_dest  <= Dest_in;
                        lat_pc    <= PC_in;
                        lat_alu   <= ALU_result_in;
                        count     <= '0;
                        state     <= BUSY;
                    end else begin
                        WB_en      <= WB_en_in & ~misaligned;
                        MEM_R_EN   <= MEM_R_EN_in & ~misaligned;
                        ALU_result <= ALU_result_in;
                        Dest       <= Dest_in;
                        PC         <= PC_in;
                        misalign   <= misaligned;
                    end
                end
                BUSY: begin
                    count <= count + 8'd1;
                    if (mem_ack) begin
                        mem_req        <= 1'b0;
                        WB_en          <= lat_wb_en;
                        MEM_R_EN       <= lat_r_en;
                        ALU_result     <= lat_alu;
                        Dest           <= lat_dest;
                        PC             <= lat_pc;
                        MEM_read_value <= mem_we ? 32'd0 : mem_rdata;
                        state          <= DONE;
                    end else if (count == 8'(TIMEOUT - 1)) begin
                        // Aborted access must never write back.
                        mem_req    <= 1'b0;
                        mem_err    <= 1'b1;
                        MEM_R_EN   <= lat_r_en;
                        ALU_result <= lat_alu;
                        Dest       <= lat_dest;
                        PC         <= lat_pc;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
